// File: rtl/resonator_mac_sequencer.sv
// Time-multiplexed 2nd-order resonator sharing a single 16x16 multiplier over four MAC cycles per sample.
// Optional output saturation is enabled by defining RESONATOR_SAT_EN; the default build wraps.
module resonator_mac_sequencer #(
  parameter logic signed [15:0] B0_INIT = 16'sh0008,
  parameter logic signed [15:0] B2_INIT = 16'shFFF7,
  parameter logic signed [15:0] A1_INIT = 16'shC51C,
  parameter logic signed [15:0] A2_INIT = 16'sh1FEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, MB0, MB2, MA1, MA2, OUT} state_t;

  localparam logic signed [15:0] COEF_INIT [4] = '{B0_INIT, B2_INIT, A1_INIT, A2_INIT};

  state_t             state_reg;
  logic signed [15:0] x_reg, x1_reg, x2_reg, y1_reg, y2_reg;
  logic signed [17:0] acc_reg, acc_next;
  logic signed [15:0] coef [4];
  logic               m_valid_reg;
  logic [15:0]        m_data_reg;

  logic signed [15:0] coef_sel, operand;
  logic               subtract;
  logic signed [31:0] prod;
  logic signed [17:0] term;
  logic [15:0]        y_next;
  logic               unused_prod_bits;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_coef
      logic signed [15:0] coef_q;
      always_ff @(posedge clk) begin
        if (reset)
          coef_q <= COEF_INIT[gi];
        else if (cfg_we && state_reg == IDLE && cfg_addr == 2'(gi))
          coef_q <= cfg_data;
      end
      assign coef[gi] = coef_q;
    end
  endgenerate

  always_comb begin
    coef_sel = coef[0];
    operand  = x_reg;
    subtract = 1'b0;
    case (state_reg)
      MB2: begin coef_sel = coef[1]; operand = x2_reg; end
      MA1: begin coef_sel = coef[2]; operand = y1_reg; subtract = 1'b1; end
      MA2: begin coef_sel = coef[3]; operand = y2_reg; subtract = 1'b1; end
      default: ;
    endcase
  end

  // Dropping the low 15 bits floors the Q1.15 product toward -inf.
  assign prod             = coef_sel * operand;
  assign term             = {{2{prod[30]}}, prod[30:15]};
  assign acc_next         = subtract ? (acc_reg - term) : (acc_reg + term);
  assign unused_prod_bits = ^{prod[31], prod[14:0]};

`ifdef RESONATOR_SAT_EN
  logic signed [19:0] acc_x4;
  assign acc_x4 = {acc_next, 2'b00};
  always_comb begin
    if (acc_x4 > 20'sd32767)
      y_next = 16'h7FFF;
    else if (acc_x4 < -20'sd32768)
      y_next = 16'h8000;
    else
      y_next = acc_x4[15:0];
  end
`else
  assign y_next = {acc_next[13:0], 2'b00};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      x1_reg      <= '0;
      x2_reg      <= '0;
      y1_reg      <= '0;
      y2_reg      <= '0;
      acc_reg     <= '0;
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (s_valid) begin
            x_reg     <= s_data;
            acc_reg   <= '0;
            state_reg <= MB0;
          end
        end
        MB0: begin acc_reg <= acc_next; state_reg <= MB2; end
        MB2: begin acc_reg <= acc_next; state_reg <= MA1; end
        MA1: begin acc_reg <= acc_next; state_reg <= MA2; end
        MA2: begin
          acc_reg     <= acc_next;
          m_data_reg  <= y_next;
          m_valid_reg <= 1'b1;
          state_reg   <= OUT;
        end
        OUT: begin
          // History advances only when the sink actually takes the sample.
          if (m_ready) begin
            x2_reg      <= x1_reg;
            x1_reg      <= x_reg;
            y2_reg      <= y1_reg;
            y1_reg      <= m_data_reg;
            m_valid_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign s_ready = (state_reg == IDLE);
  assign busy    = (state_reg != IDLE);
  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;

endmodule

// File: tb/tb_resonator_mac_sequencer.sv
// Directed scoreboard bench for resonator_mac_sequencer; expected outputs are queued at issue time
// and a separate monitor compares them on each output handshake.
module tb_resonator_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  resonator_mac_sequencer dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end else
      $display("ok   %s: 0x%04h", name, act);
  endtask

  // Monitor: every output handshake must match the oldest queued expectation.
  initial forever begin
    @(negedge clk);
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%04h expected none", m_data);
      end else
        check("m_data", m_data, exp_q.pop_front());
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b0; cfg_we = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  // mode 0: plain; 1: b0 write held during busy; 2: b0 write in the accept cycle
  task automatic send(input logic [15:0] d, input logic [15:0] exp, input int mode,
                      input logic [15:0] cval);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 50) begin @(negedge clk); n++; end
    if (!s_ready) begin
      n_checks++; n_fail++;
      $display("FAIL s_ready_timeout: got 0 expected 1");
    end
    s_valid = 1'b1; s_data = d;
    if (mode == 2) begin cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = cval; end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_data = 16'hA5A5; cfg_we = 1'b0;
    if (mode == 1) begin cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = cval; end
    n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < 20);
    cfg_we = 1'b0;
    check("latency", 16'(n), 16'd5);
  endtask

  initial begin
    logic [15:0] ovf_exp;
`ifdef RESONATOR_SAT_EN
    ovf_exp = 16'h7FFF;
`else
    ovf_exp = 16'hFFF8;
`endif

    do_reset();
    check("rst_s_ready", 16'(s_ready), 16'd1);
    check("rst_m_valid", 16'(m_valid), 16'd0);
    check("rst_m_data", m_data, 16'h0000);
    check("rst_busy", 16'(busy), 16'd0);

    // Impulse with default coefficients
    send(16'h4000, 16'd16, 0, 16'h0);
    send(16'h0000, 16'd32, 0, 16'h0);
    send(16'h0000, 16'd28, 0, 16'h0);

    // Backpressure: output held, history must advance exactly once
    do_reset();
    @(posedge clk); #1 m_ready = 1'b0;
    send(16'h4000, 16'd16, 0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      check("bp_m_valid", 16'(m_valid), 16'd1);
      check("bp_m_data", m_data, 16'd16);
      check("bp_s_ready", 16'(s_ready), 16'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    send(16'h0000, 16'd32, 0, 16'h0);
    send(16'h0000, 16'd28, 0, 16'h0);

    // Config write while busy is ignored; in IDLE it lands
    do_reset();
    send(16'h4000, 16'd16, 1, 16'h7FFF);
    do_reset();
    cfg_write(2'd0, 16'h7FFF);
    send(16'h1000, 16'h3FFC, 0, 16'h0);

    // Overflow
    do_reset();
    cfg_write(2'd0, 16'h7FFF);
    cfg_write(2'd1, 16'h0000);
    cfg_write(2'd2, 16'h0000);
    cfg_write(2'd3, 16'h0000);
    send(16'h7FFF, ovf_exp, 0, 16'h0);

    // Reset while in MA1 abandons the sample and restores coefficients
    do_reset();
    cfg_write(2'd0, 16'h7FFF);
    @(negedge clk);
    s_valid = 1'b1; s_data = 16'h7FFF;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("ma1_busy", 16'(busy), 16'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_s_ready", 16'(s_ready), 16'd1);
    check("abort_m_valid", 16'(m_valid), 16'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_quiet", 16'(m_valid), 16'd0);
    end
    send(16'h4000, 16'd16, 0, 16'h0);

    // Coefficient write and sample accept in the same cycle
    do_reset();
    send(16'h4000, 16'd32, 2, 16'h0010);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
